// File: rtl/ifs_pkg.sv
// Shared types and default widths for the instruction fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ifs_pkg;

  localparam int IFS_ADDR_W = 5;
  localparam int IFS_DATA_W = 32;
  localparam int IFS_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } ifs_state_t;

endpackage

// File: rtl/ifs_perf_counter.sv
// Saturating event counter; counts cycles with inc high, sticks at all-ones.
// Latency: count reflects inc one edge later.
// Backpressure: none (pure observer).
// Ports: clk, rst (sync, active-high), inc (event strobe), count (running total).
module ifs_perf_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Owns the PC, fetches one word per cycle from a combinational imem into an output register.
// Latency: instruction at pc appears on instr one edge after pc is driven; redirect costs one bubble.
// Backpressure: instr_valid/instr_ready; while the held word is not taken, pc and instr hold.
// Ports: clk/rst (sync, active-high); imem_addr/imem_data to instruction memory;
//   redirect_valid/redirect_addr and halt_req from control; instr_valid/instr/instr_pc/
//   instr_ready to decode; halted status.
// Optional: define IFS_PERF_CNT_EN to add fetch_count (saturating handshake counter).
module instr_fetch_sequencer
  import ifs_pkg::*;
#(
  parameter int                ADDR_W   = IFS_ADDR_W,
  parameter int                DATA_W   = IFS_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt_req,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              halted
`ifdef IFS_PERF_CNT_EN
  ,
  output logic [IFS_CNT_W-1:0] fetch_count
`endif
);

  ifs_state_t        state, state_d;
  logic [ADDR_W-1:0] pc, pc_d;
  logic              valid_d;
  logic              load;
  logic              load_ok;

  // Output register is free when empty or being consumed this cycle.
  assign load_ok   = !instr_valid || instr_ready;
  assign imem_addr = pc;
  assign halted    = (state == HALT);

  always_comb begin
    state_d = state;
    pc_d    = pc;
    valid_d = instr_valid;
    load    = 1'b0;
    unique case (state)
      IDLE: state_d = RUN;
      RUN: begin
        if (redirect_valid) begin
          // Redirect always wins over a load; a concurrent halt still takes effect.
          pc_d    = redirect_addr;
          valid_d = 1'b0;
          if (halt_req) state_d = HALT;
        end else if (halt_req) begin
          if (load_ok) begin
            valid_d = 1'b0;
            state_d = HALT;
          end else begin
            state_d = DRAIN;
          end
        end else if (load_ok) begin
          load    = 1'b1;
          valid_d = 1'b1;
          pc_d    = pc + 1'b1;  // wraps modulo 2^ADDR_W
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          // Flushing the held word empties the output, so the pending halt completes.
          pc_d    = redirect_addr;
          valid_d = 1'b0;
          state_d = HALT;
        end else if (instr_ready) begin
          valid_d = 1'b0;
          state_d = HALT;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          pc_d    = redirect_addr;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      instr_valid <= valid_d;
      if (load) begin
        instr    <= imem_data;
        instr_pc <= pc;
      end
    end
  end

`ifdef IFS_PERF_CNT_EN
  logic handshake;
  assign handshake = instr_valid && instr_ready;

  ifs_perf_counter #(
    .W(IFS_CNT_W)
  ) u_perf_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (handshake),
    .count(fetch_count)
  );
`endif

endmodule
